rr_bus_arb: RTL and testbench
=============================

RR_BUS_ARB -- requirements
Module: rr_bus_arb

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 8, setting the maximum consecutive grant cycles per ownership; legal range 1..15.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port en, input, 1, enabling new grants only.
REQ-005 The block SHALL have port req, input, 4, one request line per requester; bit i is requester i.
REQ-006 The block SHALL have port last, input, 1, an early-release strobe from the current owner, qualified by a grant being active.
REQ-007 The block SHALL have port gnt, output, 4, registered grant, one-hot or zero.
REQ-008 The block SHALL have port gnt_id, output, 2, the encoded index of the current or most recent owner.
REQ-009 The block SHALL have port busy, output, 1, high when the state is not IDLE.
REQ-010 The block SHALL have port prio, output, 2, the index of the current highest-priority requester.
REQ-011 The block SHALL have port burst_cnt, output, 4, the number of grant cycles already completed by the current owner.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, GRANT and GAP.
REQ-013 Arbitration SHALL pick the first asserted req bit searching prio, prio+1, prio+2, prio+3 (mod 4).
REQ-014 IDLE: if en=1 and req!=0 at an edge, the block SHALL set gnt one-hot to the winner, set gnt_id, clear burst_cnt to 0, and enter GRANT; otherwise it SHALL stay in IDLE with gnt=0.
REQ-015 Latency SHALL be one cycle: a req sampled at edge t yields gnt high in the cycle after edge t.
REQ-016 GRANT: the release condition SHALL be ~req[gnt_id] | last | (burst_cnt == MAX_BURST-1).
REQ-017 GRANT without release: gnt SHALL hold and burst_cnt SHALL increment by 1.
REQ-018 GRANT with release: the next edge SHALL clear gnt to 0, set prio to gnt_id+1 mod 4, clear burst_cnt, and enter GAP.
REQ-019 A continuously requesting owner with last=0 SHALL hold gnt for exactly MAX_BURST cycles.
REQ-020 GAP SHALL be exactly one dead cycle with gnt=0; at its end it SHALL arbitrate as in IDLE (REQ-014) using the updated prio, entering GRANT on a winner and IDLE otherwise.
REQ-021 There SHALL be no preemption: a new or higher-priority req SHALL not affect the current owner.
REQ-022 en=0 in GRANT SHALL NOT terminate the current ownership; it only blocks new grants in IDLE and GAP.
REQ-023 Simultaneous release conditions SHALL behave as a single release.
REQ-024 prio SHALL advance even when no other requester is pending.
REQ-025 The block SHALL NOT assert more than one gnt bit at any time.
REQ-026 gnt SHALL never be high in IDLE or GAP.
REQ-027 gnt_id SHALL retain the last owner's index while in IDLE and GAP.
REQ-028 burst_cnt SHALL never exceed MAX_BURST-1.

Reset
REQ-029 On a clock edge with reset=1, the block SHALL enter IDLE with gnt=0, gnt_id=0, prio=0, burst_cnt=0 and busy=0, regardless of state or inputs.
REQ-030 Reset SHALL take priority over all other inputs.
REQ-031 Reset asserted mid-GRANT SHALL drop gnt in the cycle after that edge.
REQ-032 The first arbitration after reset SHALL use prio=0.

Verification
REQ-033 MAX_BURST=8, reset, en=1, req=4'b0101 held -> gnt=0001 for 8 cycles, then 1 cycle of 0, then gnt=0100 for 8 cycles, then 0, then 0001 again.
REQ-034 req=4'b1111 held, last pulsed on every first grant cycle -> single-cycle grants in order 0,1,2,3,0, gap between each, prio sequence 1,2,3,0.
REQ-035 Owner 2 granted, req[2] drops at cycle k -> gnt=0 from cycle k+1, prio=3, and the next winner is 3 if requesting, else 0.
REQ-036 en=0 while owner 1 is in GRANT with req=4'b1010 -> owner 1 completes its full burst, then GAP, then IDLE with busy=0 and no further grant until en=1.
REQ-037 reset=1 on the 3rd grant cycle of owner 3 -> next cycle gnt=0, prio=0, burst_cnt=0; with req=4'b1001 after release of reset -> requester 0 wins first.
REQ-038 MAX_BURST=1, req=4'b0001 held -> gnt alternates 0001 and 0000 every cycle, and burst_cnt stays 0.

Source files
------------

// File: rtl/rr_bus_arb.sv
// Four-requester round-robin bus arbiter with bounded bursts.
// After each ownership it inserts a one-cycle gap, and priority rotates past the last owner.
module rr_bus_arb #(
    parameter int MAX_BURST = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] req,
    input  logic       last,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic [1:0] prio,
    output logic [3:0] burst_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [3:0] LP_BURST_LAST = 4'(MAX_BURST - 1);

    logic [1:0] r_state;
    logic [3:0] r_gnt;
    logic [1:0] r_gnt_id;
    logic [1:0] r_prio;
    logic [3:0] r_burst_cnt;

    logic [3:0] w_req_rot;
    logic [1:0] w_win_ofs;
    logic       w_win_valid;
    logic [1:0] w_win_id;
    logic       w_release;

    // Rotate requests so that bit 0 is the current highest-priority requester.
    always_comb begin
        w_req_rot = req;
        case (r_prio)
            2'd0:    w_req_rot = req;
            2'd1:    w_req_rot = {req[0],   req[3:1]};
            2'd2:    w_req_rot = {req[1:0], req[3:2]};
            default: w_req_rot = {req[2:0], req[3]};
        endcase
    end

    always_comb begin
        w_win_valid = |w_req_rot;
        w_win_ofs   = 2'd0;
        if (w_req_rot[0]) begin
            w_win_ofs = 2'd0;
        end else if (w_req_rot[1]) begin
            w_win_ofs = 2'd1;
        end else if (w_req_rot[2]) begin
            w_win_ofs = 2'd2;
        end else begin
            w_win_ofs = 2'd3;
        end
    end

    assign w_win_id = r_prio + w_win_ofs;

    // Owner dropping its request, an early-release strobe and burst exhaustion all end ownership.
    assign w_release = ~req[r_gnt_id] | last | (r_burst_cnt == LP_BURST_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_gnt       <= 4'b0000;
            r_gnt_id    <= 2'd0;
            r_prio      <= 2'd0;
            r_burst_cnt <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE, S_GAP: begin
                    if (en && w_win_valid) begin
                        r_state     <= S_GRANT;
                        r_gnt       <= 4'b0001 << w_win_id;
                        r_gnt_id    <= w_win_id;
                        r_burst_cnt <= 4'd0;
                    end else begin
                        r_state     <= S_IDLE;
                        r_gnt       <= 4'b0000;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_state     <= S_GAP;
                        r_gnt       <= 4'b0000;
                        r_prio      <= r_gnt_id + 2'd1;
                        r_burst_cnt <= 4'd0;
                    end else begin
                        r_burst_cnt <= r_burst_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_gnt       <= 4'b0000;
                    r_burst_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign busy      = (r_state != S_IDLE);
    assign prio      = r_prio;
    assign burst_cnt = r_burst_cnt;

endmodule

// File: tb/tb_rr_bus_arb.sv
// Directed bench for rr_bus_arb: one instance with MAX_BURST=8, one with MAX_BURST=1.
// Inputs change on the falling edge; outputs are checked on the next falling edge.
module tb_rr_bus_arb;

    logic       clock = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] req;
    logic       last;

    logic [3:0] gnt8, gnt1;
    logic [1:0] id8, id1;
    logic       busy8, busy1;
    logic [1:0] prio8, prio1;
    logic [3:0] bc8, bc1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    rr_bus_arb #(.MAX_BURST(8)) u_dut8 (
        .clock(clock), .reset(reset), .en(en), .req(req), .last(last),
        .gnt(gnt8), .gnt_id(id8), .busy(busy8), .prio(prio8), .burst_cnt(bc8)
    );

    rr_bus_arb #(.MAX_BURST(1)) u_dut1 (
        .clock(clock), .reset(reset), .en(en), .req(req), .last(last),
        .gnt(gnt1), .gnt_id(id1), .busy(busy1), .prio(prio1), .burst_cnt(bc1)
    );

    task automatic cyc();
        @(negedge clock);
    endtask

    // Compares {gnt, gnt_id, busy, prio, burst_cnt} of the MAX_BURST=8 instance.
    task automatic chk8(input string tag, input logic [3:0] g, input logic [1:0] id,
                        input logic b, input logic [1:0] p, input logic [3:0] bc);
        logic [12:0] obs;
        logic [12:0] exp_v;
        obs   = {gnt8, id8, busy8, prio8, bc8};
        exp_v = {g, id, b, p, bc};
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed gnt/id/busy/prio/cnt=%b required %b", tag, obs, exp_v);
        end
    endtask

    task automatic chk1(input string tag, input logic [3:0] g, input logic [3:0] bc);
        logic [7:0] obs;
        logic [7:0] exp_v;
        obs   = {gnt1, bc1};
        exp_v = {g, bc};
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed gnt/cnt=%b required %b", tag, obs, exp_v);
        end
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        req   = 4'b0000;
        last  = 1'b0;
        cyc();
        cyc();
        chk8("reset_state", 4'b0000, 2'd0, 1'b0, 2'd0, 4'd0);

        // Two requesters holding: full 8-cycle bursts alternating with a gap.
        reset = 1'b0;
        en    = 1'b1;
        req   = 4'b0101;
        cyc(); chk8("burst0_c0", 4'b0001, 2'd0, 1'b1, 2'd0, 4'd0);
        for (int i = 1; i < 8; i++) begin
            cyc(); chk8($sformatf("burst0_c%0d", i), 4'b0001, 2'd0, 1'b1, 2'd0, 4'(i));
        end
        cyc(); chk8("burst0_gap", 4'b0000, 2'd0, 1'b1, 2'd1, 4'd0);
        cyc(); chk8("burst2_c0", 4'b0100, 2'd2, 1'b1, 2'd1, 4'd0);
        for (int i = 1; i < 8; i++) begin
            cyc(); chk8($sformatf("burst2_c%0d", i), 4'b0100, 2'd2, 1'b1, 2'd1, 4'(i));
        end
        cyc(); chk8("burst2_gap", 4'b0000, 2'd2, 1'b1, 2'd3, 4'd0);
        cyc(); chk8("burst0_again", 4'b0001, 2'd0, 1'b1, 2'd3, 4'd0);

        reset = 1'b1;
        req   = 4'b0000;
        cyc(); chk8("reset_mid_burst", 4'b0000, 2'd0, 1'b0, 2'd0, 4'd0);
        reset = 1'b0;

        // All requesting, last on each first grant cycle: single-cycle rotation.
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            cyc(); chk8($sformatf("rot_gnt%0d", k), 4'(1 << k), 2'(k), 1'b1, 2'(k), 4'd0);
            last = 1'b1;
            cyc(); chk8($sformatf("rot_gap%0d", k), 4'b0000, 2'(k), 1'b1, 2'(k + 1), 4'd0);
            last = 1'b0;
        end
        cyc(); chk8("rot_wrap", 4'b0001, 2'd0, 1'b1, 2'd0, 4'd0);
        last = 1'b1;
        req  = 4'b0000;
        cyc(); chk8("dual_release", 4'b0000, 2'd0, 1'b1, 2'd1, 4'd0);
        last = 1'b0;
        cyc(); chk8("idle_keeps_id", 4'b0000, 2'd0, 1'b0, 2'd1, 4'd0);

        // Owner 2 drops its request; then owner 3 is not preempted by requester 0.
        req = 4'b0100;
        cyc(); chk8("own2_c0", 4'b0100, 2'd2, 1'b1, 2'd1, 4'd0);
        cyc(); chk8("own2_c1", 4'b0100, 2'd2, 1'b1, 2'd1, 4'd1);
        req = 4'b1000;
        cyc(); chk8("own2_drop", 4'b0000, 2'd2, 1'b1, 2'd3, 4'd0);
        cyc(); chk8("own3_after_gap", 4'b1000, 2'd3, 1'b1, 2'd3, 4'd0);
        req = 4'b1001;
        cyc(); chk8("no_preempt", 4'b1000, 2'd3, 1'b1, 2'd3, 4'd1);
        req = 4'b0001;
        cyc(); chk8("own3_drop", 4'b0000, 2'd3, 1'b1, 2'd0, 4'd0);
        cyc(); chk8("own0_wrap", 4'b0001, 2'd0, 1'b1, 2'd0, 4'd0);

        reset = 1'b1;
        req   = 4'b0000;
        cyc(); chk8("reset_2", 4'b0000, 2'd0, 1'b0, 2'd0, 4'd0);
        reset = 1'b0;

        // en dropped during ownership: burst completes, then no new grant.
        req = 4'b1010;
        cyc(); chk8("en_own1_c0", 4'b0010, 2'd1, 1'b1, 2'd0, 4'd0);
        en = 1'b0;
        for (int i = 1; i < 8; i++) begin
            cyc(); chk8($sformatf("en_own1_c%0d", i), 4'b0010, 2'd1, 1'b1, 2'd0, 4'(i));
        end
        cyc(); chk8("en_gap", 4'b0000, 2'd1, 1'b1, 2'd2, 4'd0);
        cyc(); chk8("en_idle_a", 4'b0000, 2'd1, 1'b0, 2'd2, 4'd0);
        cyc(); chk8("en_idle_b", 4'b0000, 2'd1, 1'b0, 2'd2, 4'd0);
        en = 1'b1;
        cyc(); chk8("en_resume", 4'b1000, 2'd3, 1'b1, 2'd2, 4'd0);

        reset = 1'b1;
        req   = 4'b0000;
        cyc(); chk8("reset_3", 4'b0000, 2'd0, 1'b0, 2'd0, 4'd0);
        reset = 1'b0;

        // Reset on owner 3's third grant cycle, with requests still active.
        req = 4'b1000;
        cyc(); chk8("own3r_c0", 4'b1000, 2'd3, 1'b1, 2'd0, 4'd0);
        cyc(); chk8("own3r_c1", 4'b1000, 2'd3, 1'b1, 2'd0, 4'd1);
        cyc(); chk8("own3r_c2", 4'b1000, 2'd3, 1'b1, 2'd0, 4'd2);
        reset = 1'b1;
        req   = 4'b1001;
        cyc(); chk8("reset_in_grant", 4'b0000, 2'd0, 1'b0, 2'd0, 4'd0);
        reset = 1'b0;
        cyc(); chk8("post_reset_prio0", 4'b0001, 2'd0, 1'b1, 2'd0, 4'd0);

        // MAX_BURST=1 instance: a lone requester alternates grant and gap.
        reset = 1'b1;
        req   = 4'b0000;
        cyc(); chk1("mb1_reset", 4'b0000, 4'd0);
        reset = 1'b0;
        req   = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            cyc(); chk1($sformatf("mb1_c%0d", i), (i % 2 == 0) ? 4'b0001 : 4'b0000, 4'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
